bytecode_fetch_unit: RTL and testbench
======================================

Name: bytecode_fetch_unit

Overview:
Upstream byte source for the JVM-to-ARM translation state machine. Streams bytecode bytes one per start/ready handshake from a 32-bit-wide synchronous bytecode ROM, holding up to WORD_FIFO_DEPTH words in a prefetch queue. Supports a PC reload and flush when the translator restarts at a new method or branch target, and flags end of code.

Parameters:
RAM_SIZE, 1024, bytecode memory size in bytes; must be a multiple of 4
ADDRESS_WIDTH, 10, byte address width; must equal log2(RAM_SIZE)
WORD_FIFO_DEPTH, 2, prefetch queue depth in 32-bit words; must be a power of 2 and >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_reset  in  1  synchronous flush plus PC reload from pc_load_addr
pc_load_addr  in  ADDRESS_WIDTH  byte address loaded on pc_reset
start  in  1  one-cycle request for the next byte
next_byte  out  8  delivered byte; valid only while ready=1
ready  out  1  one-cycle pulse: request satisfied
byte_pc  out  ADDRESS_WIDTH  byte address of next_byte; valid with ready
end_of_code  out  1  sticky: delivery pointer reached RAM_SIZE
busy  out  1  request pending
mem_addr  out  ADDRESS_WIDTH-2  word address to bytecode ROM
mem_rd  out  1  ROM read strobe
mem_rdata  in  32  ROM data, valid exactly 1 cycle after mem_rd

Behaviour:
- Reset (rst=1): ready=0, next_byte=0, byte_pc=0, end_of_code=0, busy=0, mem_rd=0, mem_addr=0. Queue empty, fetch PC=0, delivery PC=0, no request pending. rst overrides every other input.
- Byte order: big-endian within a word. Byte at address 4k+0 is mem_rdata[31:24]; byte at 4k+3 is [7:0].
- Consumer FSM states:
  - C_IDLE: start=1 goes to C_WAIT.
  - C_WAIT: when the queue head holds a byte, emit ready=1 with next_byte, byte_pc=delivery PC. Advance delivery PC by 1. Pop the head word after its byte offset 3 is consumed. Return to C_IDLE.
  - start while in C_WAIT is ignored; there is never more than one outstanding request.
- Latency: byte already queued when start is sampled gives ready on the next cycle (1 cycle). Empty queue gives ready 1 cycle after the word is written.
- Fetch FSM states:
  - F_IDLE: issue mem_rd=1, mem_addr=fetch PC[ADDRESS_WIDTH-1:2] when the queue has a free slot counting the in-flight read and fetch PC < RAM_SIZE. Go to F_WAIT.
  - F_WAIT: write mem_rdata into the queue, advance fetch PC by 4 (word-aligned), return to F_IDLE.
  - Maximum one read in flight.
- A word may be written and a word popped in the same cycle. Occupancy is unchanged.
- Unaligned start: after pc_reset, the delivery byte offset is pc_load_addr[1:0]. Fetch begins at word pc_load_addr[ADDRESS_WIDTH-1:2]. Leading bytes are skipped, never delivered.
- pc_reset (sync):
  - Empties the queue and cancels any pending request.
  - Forces ready=0 that cycle.
  - Loads both PCs and clears end_of_code.
  - Discards the response of any read issued before or in that cycle (drop flag set for the returning cycle).
  - pc_reset with start in the same cycle: pc_reset wins and the start is lost.
  - pc_reset during rst: rst wins.
- End of code: when the delivery PC equals RAM_SIZE (pointer wrap to 0 in ADDRESS_WIDTH bits plus a carry bit), end_of_code=1 sticky. A pending or new request then completes next cycle with ready=1, next_byte=8'h00, byte_pc=RAM_SIZE-1 (saturated), so the translator never deadlocks. No further mem_rd is issued.
- pc_load_addr >= RAM_SIZE cannot occur (width-bounded); no check needed.

Decomposition:
- Shared package bfu_pkg:
  - consumer state enum (C_IDLE, C_WAIT)
  - fetch state enum (F_IDLE, F_WAIT)
  - BYTE_NOP = 8'h00
  - helper constant WORD_ADDR_WIDTH = ADDRESS_WIDTH-2
- One natural sub-module: bfu_word_fifo, a synchronous word queue.
  - Ports: push, pop, flush, full, empty, count.
  - Simultaneous push and pop are legal.
  - flush has priority over push and pop.

Test Plan:
- ROM words 0x1000=0x10_2A_B1_00 at word 0; after rst, 4 start pulses spaced 3 cycles -> next_byte 0x10, 0x2A, 0xB1, 0x00 with byte_pc 0..3; first ready within 3 cycles of start, later ones exactly 1 cycle after start.
- Back-to-back start every 2 cycles across 12 bytes -> no gaps after prefetch, mem_rd never asserted with a full queue counting the in-flight read, bytes in address order.
- pc_reset with pc_load_addr=0x006 while a read is in flight -> in-flight data dropped, next start returns byte at address 6 with byte_pc=6, bytes 4 and 5 never delivered.
- pc_reset and start in the same cycle -> no ready in the following 2 cycles, busy=0.
- pc_load_addr=RAM_SIZE-2, 3 starts -> bytes at 1022 and 1023, then the third start gives ready with 8'h00, end_of_code=1, no mem_rd afterwards; a later pc_reset clears end_of_code.
- rst asserted mid-C_WAIT -> next cycle every output at its reset value; a later start fetches from address 0.

Source files
------------

// File: rtl/bfu_pkg.sv
// Shared types and constants for the bytecode fetch unit.
package bfu_pkg;

   typedef enum logic {
      C_IDLE,
      C_WAIT
   } cons_state_e;

   typedef enum logic {
      F_IDLE,
      F_WAIT
   } fetch_state_e;

   localparam logic [7:0] BYTE_NOP = 8'h00;

   localparam int unsigned ADDRESS_WIDTH   = 10;
   localparam int unsigned WORD_ADDR_WIDTH = ADDRESS_WIDTH - 2;

   // Word address width for an arbitrary byte address width.
   function automatic int unsigned word_addr_w(input int unsigned aw);
      return aw - 2;
   endfunction

endpackage

// File: rtl/bfu_word_fifo.sv
// Synchronous word queue; flush beats push and pop, push and pop may coincide.
module bfu_word_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [Width-1:0]         wdata,
   output logic [Width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_q, wr_d;
   logic [PtrW-1:0]  rd_q, rd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CntW'(Depth));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rdata   = mem_q[rd_q];
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PtrW'(1);
         if (do_pop)  rd_d = rd_q + PtrW'(1);
         cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) mem_q[wr_q] <= wdata;
   end

endmodule

// File: rtl/bytecode_fetch_unit.sv
// Streams bytecode bytes one per start/ready handshake from a word-wide ROM,
// prefetching words into a small queue; supports PC reload/flush and end of code.
module bytecode_fetch_unit
   import bfu_pkg::*;
#(
   parameter int unsigned RAM_SIZE        = 1024,
   parameter int unsigned ADDRESS_WIDTH   = 10,
   parameter int unsigned WORD_FIFO_DEPTH = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    pc_reset,
   input  logic [ADDRESS_WIDTH-1:0]                pc_load_addr,
   input  logic                                    start,
   output logic [7:0]                              next_byte,
   output logic                                    ready,
   output logic [ADDRESS_WIDTH-1:0]                byte_pc,
   output logic                                    end_of_code,
   output logic                                    busy,
   output logic [word_addr_w(ADDRESS_WIDTH)-1:0]   mem_addr,
   output logic                                    mem_rd,
   input  logic [31:0]                             mem_rdata
);

   localparam int unsigned PcW  = ADDRESS_WIDTH + 1;
   localparam int unsigned CntW = $clog2(WORD_FIFO_DEPTH) + 1;
   localparam int unsigned OccW = CntW + 1;
   localparam logic [PcW-1:0] RamEnd = PcW'(RAM_SIZE);

   cons_state_e      cstate_q, cstate_d;
   fetch_state_e     fstate_q, fstate_d;
   logic [PcW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PcW-1:0]   deliv_pc_q, deliv_pc_d;
   logic             drop_q, drop_d;

   logic             push, pop, full, empty;
   logic [CntW-1:0]  count;
   logic [31:0]      head_word;
   logic [7:0]       head_byte;
   logic [OccW-1:0]  occ;
   logic             slot_free, at_end, fetch_done;

   bfu_word_fifo #(
      .Depth (WORD_FIFO_DEPTH),
      .Width (32)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (pc_reset),
      .wdata (mem_rdata),
      .rdata (head_word),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Occupancy including the read currently returning from the ROM.
   assign occ        = OccW'(count) + OccW'(fstate_q == F_WAIT);
   assign slot_free  = !full && (occ < OccW'(WORD_FIFO_DEPTH));
   assign at_end     = (deliv_pc_q == RamEnd);
   assign fetch_done = (fetch_pc_q >= RamEnd);

   assign end_of_code = at_end && !rst;
   assign busy        = (cstate_q == C_WAIT) && !rst;

   // Big-endian byte select within the head word.
   always_comb begin
      head_byte = head_word[31:24];
      unique case (deliv_pc_q[1:0])
         2'd0: head_byte = head_word[31:24];
         2'd1: head_byte = head_word[23:16];
         2'd2: head_byte = head_word[15:8];
         2'd3: head_byte = head_word[7:0];
         default: head_byte = head_word[31:24];
      endcase
   end

   // Consumer side: one outstanding request, delivered from the queue head.
   always_comb begin
      cstate_d   = cstate_q;
      deliv_pc_d = deliv_pc_q;
      ready      = 1'b0;
      next_byte  = BYTE_NOP;
      byte_pc    = '0;
      pop        = 1'b0;
      if (!rst) begin
         if (pc_reset) begin
            cstate_d   = C_IDLE;
            deliv_pc_d = {1'b0, pc_load_addr};
         end else begin
            unique case (cstate_q)
               C_IDLE: if (start) cstate_d = C_WAIT;
               C_WAIT: begin
                  if (at_end) begin
                     ready    = 1'b1;
                     byte_pc  = ADDRESS_WIDTH'(RAM_SIZE - 1);
                     cstate_d = C_IDLE;
                  end else if (!empty) begin
                     ready      = 1'b1;
                     next_byte  = head_byte;
                     byte_pc    = deliv_pc_q[ADDRESS_WIDTH-1:0];
                     deliv_pc_d = deliv_pc_q + PcW'(1);
                     pop        = (deliv_pc_q[1:0] == 2'd3);
                     cstate_d   = C_IDLE;
                  end
               end
               default: cstate_d = C_IDLE;
            endcase
         end
      end
   end

   // Fetch side: at most one ROM read in flight; a read issued during pc_reset is dropped.
   always_comb begin
      fstate_d   = fstate_q;
      fetch_pc_d = fetch_pc_q;
      drop_d     = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      push       = 1'b0;
      if (!rst) begin
         unique case (fstate_q)
            F_IDLE: begin
               if (slot_free && !fetch_done) begin
                  mem_rd   = 1'b1;
                  mem_addr = fetch_pc_q[ADDRESS_WIDTH-1:2];
                  fstate_d = F_WAIT;
                  drop_d   = pc_reset;
               end
            end
            F_WAIT: begin
               if (!drop_q && !pc_reset) begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + PcW'(4);
               end
               fstate_d = F_IDLE;
            end
            default: fstate_d = F_IDLE;
         endcase
         if (pc_reset) fetch_pc_d = {1'b0, pc_load_addr[ADDRESS_WIDTH-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cstate_q   <= C_IDLE;
         fstate_q   <= F_IDLE;
         fetch_pc_q <= '0;
         deliv_pc_q <= '0;
         drop_q     <= 1'b0;
      end else begin
         cstate_q   <= cstate_d;
         fstate_q   <= fstate_d;
         fetch_pc_q <= fetch_pc_d;
         deliv_pc_q <= deliv_pc_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_bytecode_fetch_unit.sv
// Directed self-checking bench for bytecode_fetch_unit with a synchronous ROM model.
module tb_bytecode_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_reset;
   logic [9:0]  pc_load_addr;
   logic        start;
   logic [7:0]  next_byte;
   logic        ready;
   logic [9:0]  byte_pc;
   logic        end_of_code;
   logic        busy;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata = 32'h0;

   int checks   = 0;
   int failures = 0;
   int rd_full_viol = 0;

   logic [31:0] rom [256];

   bytecode_fetch_unit #(
      .RAM_SIZE        (1024),
      .ADDRESS_WIDTH   (10),
      .WORD_FIFO_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_reset     (pc_reset),
      .pc_load_addr (pc_load_addr),
      .start        (start),
      .next_byte    (next_byte),
      .ready        (ready),
      .byte_pc      (byte_pc),
      .end_of_code  (end_of_code),
      .busy         (busy),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

   // A read may only be issued while the queue (no read in flight) has room.
   always @(negedge clk) if (!rst && mem_rd && dut.u_fifo.count >= 2) rd_full_viol++;

   function automatic logic [7:0] exp_byte(input int a);
      logic [31:0] w;
      w = 32'h102AB100;
      if (a < 4) return w[31-8*a -: 8];
      return 8'((a * 7 + 3) & 255);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, wait (bounded) for ready, then move past the ready cycle.
   task automatic req(output bit got, output logic [7:0] b, output logic [9:0] pc,
                      output int lat);
      int n;
      got = 1'b0; b = 8'h0; pc = 10'h0; lat = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      n = 1;
      while (!got && n <= 10) begin
         if (ready) begin
            got = 1'b1; b = next_byte; pc = byte_pc; lat = n;
         end else begin
            n++;
            step();
         end
      end
      step();
   endtask

   task automatic do_pc_reset(input logic [9:0] addr);
      pc_reset = 1'b1;
      pc_load_addr = addr;
      step();
      pc_reset = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; pc_reset = 1'b0; pc_load_addr = 10'h0; start = 1'b0;
      repeat (3) step();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready); end
      checks++; if (next_byte !== 8'h00) begin failures++; $display("FAIL reset_next_byte got=%h want=00", next_byte); end
      checks++; if (byte_pc !== 10'h0) begin failures++; $display("FAIL reset_byte_pc got=%0d want=0", byte_pc); end
      checks++; if (end_of_code !== 1'b0) begin failures++; $display("FAIL reset_eoc got=%b want=0", end_of_code); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
      checks++; if (mem_addr !== 8'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
      rst = 1'b0;
   endtask

   task automatic test_first_word();
      bit got; logic [7:0] b; logic [9:0] pc; int lat;
      for (int i = 0; i < 4; i++) begin
         req(got, b, pc, lat);
         checks++;
         if (!got || b !== exp_byte(i) || pc !== 10'(i)) begin
            failures++;
            $display("FAIL first_word_byte%0d got=%b/%h/%0d want=1/%h/%0d", i, got, b, pc,
                     exp_byte(i), i);
         end
         checks++;
         if (i == 0 ? (lat > 3 || lat < 1) : (lat != 1)) begin
            failures++;
            $display("FAIL first_word_latency%0d got=%0d want=%s", i, lat, i == 0 ? "<=3" : "1");
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      bit got; logic [7:0] b; logic [9:0] pc; int lat;
      for (int i = 0; i < 12; i++) begin
         req(got, b, pc, lat);
         checks++;
         if (!got || b !== exp_byte(4 + i) || pc !== 10'(4 + i)) begin
            failures++;
            $display("FAIL b2b_byte%0d got=%b/%h/%0d want=1/%h/%0d", i, got, b, pc,
                     exp_byte(4 + i), 4 + i);
         end
         checks++;
         if (lat != 1) begin
            failures++;
            $display("FAIL b2b_latency%0d got=%0d want=1", i, lat);
         end
      end
      checks++;
      if (rd_full_viol != 0) begin
         failures++;
         $display("FAIL b2b_rd_when_full got=%0d want=0", rd_full_viol);
      end
   endtask

   task automatic test_pc_reset_inflight();
      bit got; logic [7:0] b; logic [9:0] pc; int lat; int n;
      do_pc_reset(10'h000);
      n = 0;
      while (!mem_rd && n < 6) begin n++; step(); end
      checks++;
      if (!mem_rd) begin failures++; $display("FAIL inflight_no_read got=0 want=1"); end
      step();
      do_pc_reset(10'h006);
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== exp_byte(6) || pc !== 10'd6) begin
         failures++;
         $display("FAIL inflight_byte6 got=%b/%h/%0d want=1/%h/6", got, b, pc, exp_byte(6));
      end
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== exp_byte(7) || pc !== 10'd7) begin
         failures++;
         $display("FAIL inflight_byte7 got=%b/%h/%0d want=1/%h/7", got, b, pc, exp_byte(7));
      end
      // pc_reset in the very cycle a read is issued: that response must be dropped.
      do_pc_reset(10'h000);
      n = 0;
      while (!mem_rd && n < 6) begin n++; step(); end
      do_pc_reset(10'h00E);
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== exp_byte(14) || pc !== 10'd14) begin
         failures++;
         $display("FAIL drop_byte14 got=%b/%h/%0d want=1/%h/14", got, b, pc, exp_byte(14));
      end
   endtask

   task automatic test_reset_with_start();
      bit got; logic [7:0] b; logic [9:0] pc; int lat;
      start = 1'b1;
      do_pc_reset(10'h020);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ready !== 1'b0) begin failures++; $display("FAIL rst_start_ready%0d got=%b want=0", i, ready); end
         checks++;
         if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy%0d got=%b want=0", i, busy); end
         step();
      end
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== exp_byte(32) || pc !== 10'd32) begin
         failures++;
         $display("FAIL rst_start_byte32 got=%b/%h/%0d want=1/%h/32", got, b, pc, exp_byte(32));
      end
   endtask

   task automatic test_end_of_code();
      bit got; logic [7:0] b; logic [9:0] pc; int lat; int rds;
      do_pc_reset(10'd1022);
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== 8'hF5 || pc !== 10'd1022) begin
         failures++;
         $display("FAIL eoc_byte1022 got=%b/%h/%0d want=1/f5/1022", got, b, pc);
      end
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== 8'hFC || pc !== 10'd1023) begin
         failures++;
         $display("FAIL eoc_byte1023 got=%b/%h/%0d want=1/fc/1023", got, b, pc);
      end
      checks++;
      if (end_of_code !== 1'b1) begin failures++; $display("FAIL eoc_flag got=%b want=1", end_of_code); end
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== 8'h00 || pc !== 10'd1023 || lat != 1) begin
         failures++;
         $display("FAIL eoc_nop got=%b/%h/%0d/lat%0d want=1/00/1023/lat1", got, b, pc, lat);
      end
      rds = 0;
      for (int i = 0; i < 6; i++) begin
         if (mem_rd) rds++;
         step();
      end
      checks++;
      if (rds != 0) begin failures++; $display("FAIL eoc_mem_rd got=%0d want=0", rds); end
      checks++;
      if (end_of_code !== 1'b1) begin failures++; $display("FAIL eoc_sticky got=%b want=1", end_of_code); end
      do_pc_reset(10'h000);
      checks++;
      if (end_of_code !== 1'b0) begin failures++; $display("FAIL eoc_clear got=%b want=0", end_of_code); end
   endtask

   task automatic test_rst_mid_wait();
      bit got; logic [7:0] b; logic [9:0] pc; int lat;
      do_pc_reset(10'h040);
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_wait_state got=busy%b/ready%b want=busy1/ready0", busy, ready);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({ready, busy, mem_rd, end_of_code, next_byte, byte_pc, mem_addr} !== 30'h0) begin
         failures++;
         $display("FAIL mid_wait_rst got=r%b b%b m%b e%b nb%h pc%0d ma%h want=all0", ready, busy,
                  mem_rd, end_of_code, next_byte, byte_pc, mem_addr);
      end
      rst = 1'b0;
      req(got, b, pc, lat);
      checks++;
      if (!got || b !== 8'h10 || pc !== 10'd0) begin
         failures++;
         $display("FAIL mid_wait_refetch got=%b/%h/%0d want=1/10/0", got, b, pc);
      end
   endtask

   initial begin
      for (int k = 0; k < 256; k++)
         rom[k] = {exp_byte(4*k), exp_byte(4*k+1), exp_byte(4*k+2), exp_byte(4*k+3)};
      test_reset();
      test_first_word();
      test_back_to_back();
      test_pc_reset_inflight();
      test_reset_with_start();
      test_end_of_code();
      test_rst_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
